// File: rtl/mips_defs.sv
// Shared front-end definitions: reset vector, canonical NOP, fetch FSM encodings and the
// queue entry layout carried from fetch to the IF/ID register.
package mips_defs;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] FETCH_IDLE = 2'd0;
   localparam logic [1:0] FETCH_REQ  = 2'd1;
   localparam logic [1:0] FETCH_WAIT = 2'd2;

   typedef struct packed {
      logic [31:0] pc_plus_4;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc_plus_4, instr}; head is registered and visible the cycle after push.
// Flush beats push and pop; a push into a full queue without a pop is dropped and flagged.
module fetch_queue
   import mips_defs::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_dat_i,
   input  logic          pop_i,
   output fetch_entry_t  head_dat_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && !flush_i && (count_q != '0);
      do_push  = push_i && !flush_i && ((count_q != DEPTH_C) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == DEPTH_C);

   // The fetch issue rule reserves a slot per outstanding read, so this must never fire.
   assert property (@(posedge clk) disable iff (!reset)
      !(push_i && !flush_i && !pop_i && (count_q == DEPTH_C)));

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, single-outstanding imem read FSM, instruction queue, redirect flush.
// 1 instr per 2 cycles at 1-cycle memory; if_ready_i=0 holds the head, fetch stops when queue full.
module instruction_fetch_stage
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          QUEUE_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        if_ready_i,
   output logic        if_valid_o,
   output logic [31:0] if_instruction_o,
   output logic [31:0] if_pc_plus_4_o
);

   localparam int            CW      = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   logic [1:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pend_pc4_q, pend_pc4_d;
   logic          discard_q, discard_d;

   logic          q_push, q_pop, q_empty, q_full;
   logic [CW-1:0] q_count, count_after;
   fetch_entry_t  q_head, q_push_dat;

   assign q_push_dat.pc_plus_4 = pend_pc4_q;
   assign q_push_dat.instr     = imem_rdata_i;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      pend_pc4_d  = pend_pc4_q;
      discard_d   = discard_q;
      q_push      = 1'b0;
      q_pop       = !q_empty && if_ready_i && !redirect_i;
      count_after = q_count;
      if (redirect_i) begin
         // Queue is flushed this cycle, so every path restarts with an empty queue.
         fetch_pc_d = word_align(redirect_pc_i);
         case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
               if (imem_gnt_i) begin
                  state_d   = FETCH_WAIT;
                  discard_d = 1'b1;
               end else begin
                  state_d = FETCH_IDLE;
               end
            end
            FETCH_WAIT: begin
               if (imem_rvalid_i) begin
                  state_d   = FETCH_REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end
            default: state_d = FETCH_IDLE;
         endcase
      end else begin
         case (state_q)
            FETCH_IDLE: begin
               if (!q_full) begin
                  state_d = FETCH_REQ;
               end
            end
            FETCH_REQ: begin
               if (imem_gnt_i) begin
                  pend_pc4_d = fetch_pc_q + 32'd4;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (imem_rvalid_i) begin
                  q_push      = !discard_q;
                  discard_d   = 1'b0;
                  count_after = q_count + CW'(q_push) - CW'(q_pop);
                  state_d     = (count_after < DEPTH_C) ? FETCH_REQ : FETCH_IDLE;
               end
            end
            default: state_d = FETCH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH_IDLE;
         fetch_pc_q <= RESET_PC;
         pend_pc4_q <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc4_q <= pend_pc4_d;
         discard_q  <= discard_d;
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (redirect_i),
      .push_i     (q_push),
      .push_dat_i (q_push_dat),
      .pop_i      (q_pop),
      .head_dat_o (q_head),
      .count_o    (q_count),
      .empty_o    (q_empty),
      .full_o     (q_full)
   );

   assign imem_req_o       = (state_q == FETCH_REQ);
   assign imem_addr_o      = fetch_pc_q;
   assign if_valid_o       = !q_empty;
   assign if_instruction_o = q_empty ? NOP_INSTR : q_head.instr;
   assign if_pc_plus_4_o   = q_empty ? 32'd0 : q_head.pc_plus_4;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: memory model with programmable latency,
// expected queue entries pushed on response delivery and compared at the IF/ID boundary.
module tb_instruction_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_ready_i;
   logic        if_valid_o;
   logic [31:0] if_instruction_o;
   logic [31:0] if_pc_plus_4_o;

   always #5 clk = ~clk;

   instruction_fetch_stage #(
      .RESET_PC    (RST_PC),
      .QUEUE_DEPTH (2),
      .NOP_INSTR   (NOP)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .if_ready_i       (if_ready_i),
      .if_valid_o       (if_valid_o),
      .if_instruction_o (if_instruction_o),
      .if_pc_plus_4_o   (if_pc_plus_4_o)
   );

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] gnt_log[$];
   logic [31:0] pop_log[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pop_cnt  = 0;

   logic [31:0] exp_pc;
   bit          pend, pend_kill, fired, ready_ctl, gnt_en;
   logic [31:0] pend_addr, redir_pc;
   int          pend_cnt, lat, redir_mode;

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},   32'(imem_req_o), 32'd0);
      check_eq({tag, "_addr"},  imem_addr_o, RST_PC);
      check_eq({tag, "_vld"},   32'(if_valid_o), 32'd0);
      check_eq({tag, "_instr"}, if_instruction_o, NOP);
      check_eq({tag, "_pc4"},   if_pc_plus_4_o, 32'd0);
   endtask

   // One clock: check head against scoreboard, then drive memory/redirect/ready for the next edge.
   task automatic step();
      bit          deliver, d_kill, fire;
      logic [31:0] d_addr;
      @(negedge clk);
      if (expq.size() != 0) begin
         check_eq("valid",      32'(if_valid_o), 32'd1);
         check_eq("head_pc4",   if_pc_plus_4_o, expq[0].pc4);
         check_eq("head_instr", if_instruction_o, expq[0].instr);
      end else begin
         check_eq("valid",      32'(if_valid_o), 32'd0);
         check_eq("empty_instr", if_instruction_o, NOP);
         check_eq("empty_pc4",  if_pc_plus_4_o, 32'd0);
      end

      deliver = pend && (pend_cnt == 0);
      d_addr  = pend_addr;
      d_kill  = pend_kill;
      if (pend && pend_cnt != 0) pend_cnt--;
      if (deliver) pend = 1'b0;
      imem_rvalid_i = deliver;
      imem_rdata_i  = deliver ? rd_of(d_addr) : 32'hDEAD_BEEF;

      fire = 1'b0;
      if (redir_mode == 1 && pend && !deliver) fire = 1'b1;
      if (redir_mode == 2 && deliver && expq.size() == 1) fire = 1'b1;
      if (redir_mode == 3) fire = 1'b1;
      if_ready_i    = fire ? 1'b1 : ready_ctl;
      redirect_i    = fire;
      redirect_pc_i = redir_pc;

      imem_gnt_i = imem_req_o & gnt_en;
      if (imem_gnt_i) begin
         check_eq("gnt_addr", imem_addr_o, exp_pc);
         gnt_log.push_back(imem_addr_o);
         pend      = 1'b1;
         pend_addr = exp_pc;
         pend_cnt  = lat - 1;
         pend_kill = 1'b0;
         exp_pc    = exp_pc + 32'd4;
      end

      if (fire) begin
         redir_mode = 0;
         fired      = 1'b1;
         expq.delete();
         exp_pc = redir_pc & ~32'd3;
         if (pend) pend_kill = 1'b1;
      end else begin
         if (expq.size() != 0 && if_ready_i) begin
            pop_log.push_back(expq[0].pc4);
            void'(expq.pop_front());
            pop_cnt++;
         end
         if (deliver && !d_kill) expq.push_back('{d_addr + 32'd4, rd_of(d_addr)});
      end
   endtask

   task automatic run_until_fired(input string tag, input int max_cycles);
      fired = 1'b0;
      for (int i = 0; i < max_cycles && !fired; i++) step();
      check_eq(tag, 32'(fired), 32'd1);
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      pop_log.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
      exp_pc = RST_PC; pend = 1'b0; pend_kill = 1'b0; pend_cnt = 0; pend_addr = '0;
      fired = 1'b0; ready_ctl = 1'b0; gnt_en = 1'b1; lat = 1; redir_mode = 0; redir_pc = '0;

      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;

      // Stall from reset: queue fills to two entries and fetching stops.
      clear_logs();
      repeat (10) step();
      check_eq("stall_req",   32'(imem_req_o), 32'd0);
      check_eq("stall_pc4",   if_pc_plus_4_o, 32'h0040_0004);
      check_eq("stall_instr", if_instruction_o, rd_of(RST_PC));
      check_eq("seq_addr1",   gnt_log[1], 32'h0040_0004);

      // Drain, then measure steady-state throughput.
      ready_ctl = 1'b1;
      clear_logs();
      repeat (8) step();
      check_eq("drain_pc4_0", pop_log[0], 32'h0040_0004);
      check_eq("drain_pc4_1", pop_log[1], 32'h0040_0008);
      pop_cnt = 0;
      repeat (20) step();
      check_eq("thruput", 32'(pop_cnt), 32'd10);

      // Redirect while waiting on memory (2-cycle latency gives a WAIT cycle without rvalid).
      lat = 2;
      repeat (4) step();
      redir_pc = 32'h0040_0100;
      redir_mode = 1;
      run_until_fired("t3_fired", 20);
      clear_logs();
      repeat (12) step();
      check_eq("t3_addr", gnt_log[0], 32'h0040_0100);
      check_eq("t3_pc4",  pop_log[0], 32'h0040_0104);
      lat = 1;

      // Redirect coincident with rvalid while the queue becomes full.
      ready_ctl = 1'b0;
      redir_pc = 32'h0040_0203;
      redir_mode = 2;
      run_until_fired("t4_fired", 30);
      ready_ctl = 1'b1;
      clear_logs();
      repeat (10) step();
      check_eq("t4_addr", gnt_log[0], 32'h0040_0200);

      // Redirect while a request is pending without grant.
      gnt_en = 1'b0;
      repeat (3) step();
      redir_pc = 32'h0040_0300;
      redir_mode = 3;
      step();
      gnt_en = 1'b1;
      clear_logs();
      repeat (8) step();
      check_eq("wd_addr", gnt_log[0], 32'h0040_0300);

      // PC wrap at the top of the address space.
      repeat (2) step();
      redir_pc = 32'hFFFF_FFFC;
      redir_mode = 3;
      step();
      clear_logs();
      repeat (10) step();
      check_eq("wrap_n",    32'(gnt_log.size() >= 2 && pop_log.size() >= 1), 32'd1);
      check_eq("wrap_a0",   gnt_log[0], 32'hFFFF_FFFC);
      check_eq("wrap_a1",   gnt_log[1], 32'h0000_0000);
      check_eq("wrap_pc4",  pop_log[0], 32'h0000_0000);

      // Reset in the middle of an outstanding read, then a late rvalid.
      lat = 2;
      fired = 1'b0;
      for (int i = 0; i < 20 && !fired; i++) begin
         step();
         if (pend && pend_cnt != 0) fired = 1'b1;
      end
      check_eq("t6_inflight", 32'(fired), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      expq.delete();
      pend = 1'b0; pend_kill = 1'b0; exp_pc = RST_PC; lat = 1;
      @(negedge clk);
      reset = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_BAD0;
      clear_logs();
      repeat (10) step();
      check_eq("t6_addr", gnt_log[0], RST_PC);
      check_eq("t6_pc4",  pop_log[0], 32'h0040_0004);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
